// File: rtl/uart_mem_loader_if.sv
// Byte-stream and RAM write-port bundle between buart, the boot loader and
// the ram16k port-a mux.
interface uart_mem_loader_if;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        uart_rd;
    logic        uart_busy;
    logic        uart_wr;
    logic [7:0]  tx_data;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [31:0] mem_d;

    modport master (
        input  uart_valid, uart_data, uart_busy,
        output uart_rd, uart_wr, tx_data, mem_wr, mem_addr, mem_d
    );

    modport slave (
        output uart_valid, uart_data, uart_busy,
        input  uart_rd, uart_wr, tx_data, mem_wr, mem_addr, mem_d
    );
endinterface

// File: rtl/uart_mem_loader.sv
// Serial boot loader: receives SYNC/count/words/checksum frames from buart,
// writes little-endian words into RAM and holds the j1 core in reset while loading.
module uart_mem_loader #(
    parameter logic [7:0] SYNC           = 8'hA5,
    parameter int         MAX_WORDS      = 8192,
    parameter int         TIMEOUT_CYCLES = 150000000,
    parameter bit         HOLD_AT_BOOT   = 1'b0
) (
    input  logic              clk,
    input  logic              resetq,
    uart_mem_loader_if.master bus,
    output logic              cpu_resetq,
    output logic              loading
);
    localparam logic [7:0]      ACK       = 8'h06;
    localparam logic [7:0]      NAK       = 8'h15;
    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_CNT   = 17'(MAX_WORDS);

    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, CSUM, RESP} state_t;

    state_t         state_reg, state_next;
    logic           run_reg, run_next;
    logic           cpu_resetq_reg, cpu_resetq_next;
    logic           loading_reg, loading_next;
    logic           uart_rd_reg, uart_rd_next;
    logic           rd_gap_reg, rd_gap_next;
    logic           uart_wr_reg, uart_wr_next;
    logic [7:0]     tx_data_reg, tx_data_next;
    logic           mem_wr_reg, mem_wr_next;
    logic [15:0]    mem_addr_reg, mem_addr_next;
    logic [31:0]    mem_d_reg, mem_d_next;
    logic [15:0]    count_reg, count_next;
    logic [15:0]    index_reg, index_next;
    logic [7:0]     csum_reg, csum_next;
    logic [31:0]    word_reg, word_next;
    logic [1:0]     byte_cnt_reg, byte_cnt_next;
    logic [TW-1:0]  idle_reg, idle_next;

    logic           take;
    logic           counting;
    logic [15:0]    count_full;
    logic [15:0]    index_inc;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_reg      <= IDLE;
            run_reg        <= ~HOLD_AT_BOOT;
            cpu_resetq_reg <= 1'b0;
            loading_reg    <= 1'b0;
            uart_rd_reg    <= 1'b0;
            rd_gap_reg     <= 1'b0;
            uart_wr_reg    <= 1'b0;
            tx_data_reg    <= 8'h00;
            mem_wr_reg     <= 1'b0;
            mem_addr_reg   <= 16'h0000;
            mem_d_reg      <= 32'h0000_0000;
            count_reg      <= 16'h0000;
            index_reg      <= 16'h0000;
            csum_reg       <= 8'h00;
            word_reg       <= 32'h0000_0000;
            byte_cnt_reg   <= 2'd0;
            idle_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            run_reg        <= run_next;
            cpu_resetq_reg <= cpu_resetq_next;
            loading_reg    <= loading_next;
            uart_rd_reg    <= uart_rd_next;
            rd_gap_reg     <= rd_gap_next;
            uart_wr_reg    <= uart_wr_next;
            tx_data_reg    <= tx_data_next;
            mem_wr_reg     <= mem_wr_next;
            mem_addr_reg   <= mem_addr_next;
            mem_d_reg      <= mem_d_next;
            count_reg      <= count_next;
            index_reg      <= index_next;
            csum_reg       <= csum_next;
            word_reg       <= word_next;
            byte_cnt_reg   <= byte_cnt_next;
            idle_reg       <= idle_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        run_next        = run_reg;
        cpu_resetq_next = run_reg;
        loading_next    = loading_reg;
        uart_rd_next    = 1'b0;
        rd_gap_next     = uart_rd_reg;
        uart_wr_next    = 1'b0;
        tx_data_next    = tx_data_reg;
        mem_wr_next     = 1'b0;
        mem_addr_next   = mem_addr_reg;
        mem_d_next      = mem_d_reg;
        count_next      = count_reg;
        index_next      = index_reg;
        csum_next       = csum_reg;
        word_next       = word_reg;
        byte_cnt_next   = byte_cnt_reg;

        count_full = {bus.uart_data, count_reg[7:0]};
        index_inc  = index_reg + 16'd1;
        counting   = (state_reg == CNT_LO) || (state_reg == CNT_HI) ||
                     (state_reg == DATA)   || (state_reg == CSUM);
        // valid stays high during the rd pulse and the cycle after it, so both are masked
        take       = bus.uart_valid && !uart_rd_reg && !rd_gap_reg &&
                     (state_reg != WRITE) && (state_reg != RESP);
        idle_next  = counting ? idle_reg + TW'(1) : '0;
        if (take) begin
            uart_rd_next = 1'b1;
            idle_next    = '0;
        end

        case (state_reg)
            IDLE: begin
                if (take && bus.uart_data == SYNC) begin
                    state_next    = CNT_LO;
                    run_next      = 1'b0;
                    loading_next  = 1'b1;
                    csum_next     = 8'h00;
                    index_next    = 16'h0000;
                    byte_cnt_next = 2'd0;
                end
            end
            CNT_LO: begin
                if (take) begin
                    count_next = {count_reg[15:8], bus.uart_data};
                    state_next = CNT_HI;
                end
            end
            CNT_HI: begin
                if (take) begin
                    count_next = count_full;
                    if ({1'b0, count_full} > MAX_CNT) begin
                        state_next   = RESP;
                        tx_data_next = NAK;
                    end else if (count_full == 16'h0000) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (take) begin
                    word_next     = {bus.uart_data, word_reg[31:8]};
                    csum_next     = csum_reg + bus.uart_data;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3)
                        state_next = WRITE;
                end
            end
            WRITE: begin
                mem_wr_next   = 1'b1;
                mem_addr_next = {index_reg[13:0], 2'b00};
                mem_d_next    = word_reg;
                index_next    = index_inc;
                state_next    = (index_inc < count_reg) ? DATA : CSUM;
            end
            CSUM: begin
                if (take) begin
                    tx_data_next = (bus.uart_data == csum_reg) ? ACK : NAK;
                    state_next   = RESP;
                end
            end
            RESP: begin
                if (!bus.uart_busy) begin
                    uart_wr_next = 1'b1;
                    loading_next = 1'b0;
                    state_next   = IDLE;
                    if (tx_data_reg == ACK)
                        run_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (counting && !take && idle_reg == IDLE_LAST) begin
            state_next   = RESP;
            tx_data_next = NAK;
        end
    end

    assign bus.uart_rd  = uart_rd_reg;
    assign bus.uart_wr  = uart_wr_reg;
    assign bus.tx_data  = tx_data_reg;
    assign bus.mem_wr   = mem_wr_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.mem_d    = mem_d_reg;
    assign cpu_resetq   = cpu_resetq_reg;
    assign loading      = loading_reg;
endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: expected RAM writes and response bytes
// are queued as frames are driven and compared when the loader produces them.
module tb_uart_mem_loader;
    localparam int TIMEOUT   = 100;
    localparam int MAX_WORDS = 8192;

    typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [7:0] b; logic run; } tx_t;

    logic clk;
    logic resetq;
    logic cpu_resetq;
    logic loading;

    uart_mem_loader_if bus ();

    uart_mem_loader #(
        .SYNC(8'hA5), .MAX_WORDS(MAX_WORDS),
        .TIMEOUT_CYCLES(TIMEOUT), .HOLD_AT_BOOT(1'b1)
    ) dut (
        .clk(clk), .resetq(resetq), .bus(bus),
        .cpu_resetq(cpu_resetq), .loading(loading)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cap_cyc = 0;
    int wr_cyc  = 0;
    wr_t exp_wr_q [$];
    tx_t exp_tx_q [$];
    logic [7:0] pay [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Output monitor: every write and every response byte is checked against the queues.
    initial begin
        wr_t w;
        tx_t t;
        forever begin
            @(negedge clk);
            if (bus.mem_wr === 1'b1) begin
                $display("[TB] mem_wr addr=0x%04h data=0x%08h", bus.mem_addr, bus.mem_d);
                if (exp_wr_q.size() == 0) begin
                    check_eq("mem_wr_unexpected", 32'(exp_wr_q.size()), 32'd1);
                end else begin
                    w = exp_wr_q.pop_front();
                    check_eq("mem_addr", 32'(bus.mem_addr), 32'(w.a));
                    check_eq("mem_d", bus.mem_d, w.d);
                end
            end
            if (bus.uart_wr === 1'b1) begin
                wr_cyc = cyc;
                $display("[TB] uart_wr tx=0x%02h at cycle %0d", bus.tx_data, cyc);
                if (exp_tx_q.size() == 0) begin
                    check_eq("uart_wr_unexpected", 32'(exp_tx_q.size()), 32'd1);
                end else begin
                    t = exp_tx_q.pop_front();
                    check_eq("tx_data", 32'(bus.tx_data), 32'(t.b));
                    check_eq("loading_at_wr", 32'(loading), 32'd0);
                    check_eq("cpu_resetq_at_wr", 32'(cpu_resetq), 32'd0);
                    @(negedge clk);
                    check_eq("uart_wr_width", 32'(bus.uart_wr), 32'd0);
                    check_eq("cpu_resetq_after_wr", 32'(cpu_resetq), 32'(t.run));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.uart_valid = 1'b1;
        bus.uart_data  = b;
        do begin
            @(negedge clk);
            n++;
        end while (bus.uart_rd !== 1'b1 && n < 400);
        if (bus.uart_rd !== 1'b1)
            check_eq("uart_rd_timeout", 32'(bus.uart_rd), 32'd1);
        else
            cap_cyc = cyc;
        @(posedge clk);
        #1;
        bus.uart_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (exp_tx_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_tx_q.size() != 0) begin
            check_eq("resp_timeout", 32'(exp_tx_q.size()), 32'd0);
            exp_tx_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Builds expectations from the frame contents, then drives the frame.
    task automatic run_frame(input logic [15:0] cnt, input logic [7:0] csum_b, input int busy_cycles);
        logic [7:0] sum;
        logic       ack;
        logic       cnt_bad;
        int         wr_seen;
        tx_t        t;
        sum     = 8'h00;
        cnt_bad = (32'(cnt) > MAX_WORDS);
        if (!cnt_bad) begin
            for (int i = 0; i < int'(cnt); i++) begin
                exp_wr_q.push_back('{a: 16'(i * 4),
                                     d: {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]}});
                for (int k = 0; k < 4; k++) sum = sum + pay[4*i+k];
            end
        end
        ack   = !cnt_bad && (sum == csum_b);
        t.b   = ack ? 8'h06 : 8'h15;
        t.run = ack;
        exp_tx_q.push_back(t);
        if (busy_cycles > 0) bus.uart_busy = 1'b1;
        send_byte(8'hA5);
        check_eq("loading_after_sync", 32'(loading), 32'd1);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        if (!cnt_bad) begin
            for (int i = 0; i < 4 * int'(cnt); i++) send_byte(pay[i]);
            send_byte(csum_b);
        end
        if (busy_cycles > 0) begin
            wr_seen = 0;
            for (int i = 0; i < busy_cycles; i++) begin
                @(negedge clk);
                if (bus.uart_wr === 1'b1) wr_seen++;
            end
            check_eq("busy_no_wr", 32'(wr_seen), 32'd0);
            check_eq("busy_tx_hold", 32'(bus.tx_data), 32'(t.b));
            check_eq("busy_loading", 32'(loading), 32'd1);
            @(posedge clk);
            #1;
            bus.uart_busy = 1'b0;
        end
        wait_resp();
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetq         = 1'b0;
        bus.uart_valid = 1'b0;
        bus.uart_data  = 8'h00;
        bus.uart_busy  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_resetq", 32'(cpu_resetq), 32'd0);
        check_eq("rst_loading", 32'(loading), 32'd0);
        check_eq("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check_eq("rst_uart_rd", 32'(bus.uart_rd), 32'd0);
        check_eq("rst_uart_wr", 32'(bus.uart_wr), 32'd0);
        check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
        @(posedge clk);
        #1;
        resetq = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_at_boot", 32'(cpu_resetq), 32'd0);

        // Two words, correct checksum (sum of data bytes is 0x4C)
        pay = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_frame(16'd2, 8'h4C, 0);
        check_eq("ack_cpu_run", 32'(cpu_resetq), 32'd1);

        // Same frame, bad checksum
        run_frame(16'd2, 8'h00, 0);
        check_eq("nak_cpu_held", 32'(cpu_resetq), 32'd0);

        // Empty frame
        pay.delete();
        run_frame(16'd0, 8'h00, 0);
        check_eq("empty_cpu_run", 32'(cpu_resetq), 32'd1);

        // Oversize count, then trailing bytes discarded in IDLE
        run_frame(16'h2001, 8'h00, 0);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        repeat (5) @(posedge clk);
        #1;
        check_eq("trail_loading", 32'(loading), 32'd0);
        check_eq("oversize_cpu_held", 32'(cpu_resetq), 32'd0);

        // Timeout mid-word
        exp_tx_q.push_back('{b: 8'h15, run: 1'b0});
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h78);
        wait_resp();
        check_eq("timeout_latency", 32'(wr_cyc - cap_cyc), 32'(TIMEOUT + 1));
        check_eq("timeout_cpu_held", 32'(cpu_resetq), 32'd0);

        // Busy held for 50 cycles at the response
        run_frame(16'd0, 8'h00, 50);
        check_eq("busy_cpu_run", 32'(cpu_resetq), 32'd1);

        // Reset in the middle of a data word
        pay = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        check_eq("mid_loading", 32'(loading), 32'd1);
        #1;
        resetq = 1'b0;
        #1;
        check_eq("mrst_loading", 32'(loading), 32'd0);
        check_eq("mrst_cpu_resetq", 32'(cpu_resetq), 32'd0);
        check_eq("mrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("mrst_mem_d", bus.mem_d, 32'd0);
        check_eq("mrst_tx_data", 32'(bus.tx_data), 32'd0);
        check_eq("mrst_uart_rd", 32'(bus.uart_rd), 32'd0);
        check_eq("mrst_mem_wr", 32'(bus.mem_wr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        resetq = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mrst_cpu_held", 32'(cpu_resetq), 32'd0);

        // Recovery after reset
        pay.delete();
        run_frame(16'd0, 8'h00, 0);
        check_eq("recover_cpu_run", 32'(cpu_resetq), 32'd1);

        check_eq("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
